edge_oneshot_multi: RTL

- Multi-channel, parametrised edge-to-pulse generator; successor to the single-channel positive oneshot.
- Each channel synchronises an asynchronous level input and detects rising, falling or both edges, selected per channel at run time.
- On each accepted edge it emits a registered pulse of programmable length, then applies an optional hold-off lockout.
- Sits between external trigger/timing inputs and the channel-unit control logic.

---
 rtl/oneshot_pkg.sv | 25 ++
 rtl/edge_oneshot_chan.sv | 141 ++++++++++++++
 rtl/edge_oneshot_multi.sv | 66 ++++++
 3 files changed

// File: rtl/oneshot_pkg.sv
// Shared definitions for the edge-to-pulse oneshot family: mode encodings,
// per-channel state type and the countdown-width helper.
package oneshot_pkg;

    // Per-channel edge select: bit 0 enables rising, bit 1 enables falling.
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Width of the shared pulse/hold-off countdown; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned plen,
                                              input int unsigned hold);
        int unsigned m;
        m = (plen > hold) ? plen : hold;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/edge_oneshot_chan.sv
// One oneshot channel: input synchroniser, mode-gated edge detector,
// IDLE/PULSE/HOLD sequencer and, with EDGE_COUNT_EN, a saturating event counter.
// The detected edge is registered once before the sequencer, giving a
// pulse SYNC_STAGES+1 clocks after the first capturing edge.
module edge_oneshot_chan
    import oneshot_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_LEN   = 1,
    parameter int unsigned HOLDOFF     = 0
`ifdef EDGE_COUNT_EN
   ,parameter int unsigned CNT_W       = 16
`endif
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in,
    input  logic [1:0]       i_mode,
`ifdef EDGE_COUNT_EN
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_count,
`endif
    output logic             o_pulse,
    output logic             o_pulse_nxt_c,
    output logic             o_busy
);

    localparam int unsigned   CW         = cnt_width(PULSE_LEN, HOLDOFF);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   prev_q;
    logic                   edge_q;
    logic                   rise_c;
    logic                   fall_c;
    logic                   edge_c;
    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, previous-sample flop and registered edge strobe.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= SYNC_STAGES'({sync_q, i_in});
            prev_q <= sync_s;
            edge_q <= edge_c;
        end
    end

    // Edge classification gated by the per-channel mode.
    always_comb begin
        rise_c = sync_s & ~prev_q;
        fall_c = ~sync_s & prev_q;
        edge_c = (i_mode[0] & rise_c) | (i_mode[1] & fall_c);
    end

    // Next-state and countdown; edges outside IDLE are dropped, MODE_OFF aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (edge_q) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    if (HOLDOFF > 0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (i_mode == MODE_OFF) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign o_pulse_nxt_c = (state_d == PULSE);

    // State register with outputs decoded from next state so they are plain flops.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            o_pulse <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_pulse <= (state_d == PULSE);
            o_busy  <= (state_d != IDLE);
        end
    end

`ifdef EDGE_COUNT_EN
    logic enter_c;

    assign enter_c = (state_q != PULSE) && (state_d == PULSE);

    // Saturating count of pulse starts; clear wins over a same-cycle start.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_count <= '0;
        end else if (i_cnt_clr) begin
            o_count <= '0;
        end else if (enter_c && (o_count != '1)) begin
            o_count <= o_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/edge_oneshot_multi.sv
// Multi-channel edge-to-pulse generator: N_CH independent oneshot channels
// plus a registered OR of all pulses aligned with o_pulse.
// Optional feature macro: EDGE_COUNT_EN (per-channel saturating event counters).
module edge_oneshot_multi
    import oneshot_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_LEN   = 1,
    parameter int unsigned HOLDOFF     = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_CH-1:0]       i_in,
    input  logic [2*N_CH-1:0]     i_mode,
`ifdef EDGE_COUNT_EN
    input  logic                  i_cnt_clr,
    output logic [N_CH*CNT_W-1:0] o_count,
`endif
    output logic [N_CH-1:0]       o_pulse,
    output logic                  o_any,
    output logic [N_CH-1:0]       o_busy
);

    // Reject degenerate configurations at elaboration.
    if ((N_CH == 0) || (SYNC_STAGES == 0) || (PULSE_LEN == 0) || (CNT_W == 0)) begin : g_bad_param
        $error("edge_oneshot_multi: N_CH, SYNC_STAGES, PULSE_LEN and CNT_W must be >= 1");
    end

    logic [N_CH-1:0] pulse_nxt;

    // One independent channel per input bit.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        edge_oneshot_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .PULSE_LEN   (PULSE_LEN),
            .HOLDOFF     (HOLDOFF)
`ifdef EDGE_COUNT_EN
           ,.CNT_W       (CNT_W)
`endif
        ) u_chan (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_in          (i_in[c]),
            .i_mode        (i_mode[2*c +: 2]),
`ifdef EDGE_COUNT_EN
            .i_cnt_clr     (i_cnt_clr),
            .o_count       (o_count[c*CNT_W +: CNT_W]),
`endif
            .o_pulse       (o_pulse[c]),
            .o_pulse_nxt_c (pulse_nxt[c]),
            .o_busy        (o_busy[c])
        );
    end

    // OR of the channels' next pulse values, registered to line up with o_pulse.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_any <= 1'b0;
        end else begin
            o_any <= |pulse_nxt;
        end
    end

endmodule
